mod_mul_seq: RTL and testbench

MOD_MUL_SEQ -- requirements
Module: mod_mul_seq

---
 rtl/mod_mul_seq.sv | 120 ++++++++++++
 tb/tb_mod_mul_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_mul_seq.sv
// mod_mul_seq: sequential modular multiplier, R = (A*B) mod M.
// MSB-first interleaved double-and-add. Each cycle uses one shared
// combinational modular adder (add_a + add_b) mod add_m supplied from outside.
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : begin a multiplication (sampled only in IDLE)
//   op_a     : multiplicand A (caller guarantees A < M)
//   op_b     : multiplier B
//   op_m     : modulus M (caller guarantees M > 0)
//   busy     : high while doubling/adding
//   done     : one-cycle pulse, rises together with a new result
//   result   : registered (A*B) mod M, held until the next result
//   add_a/b/m: operands to the external modular adder (0 when idle)
//   add_sum  : adder response, same cycle
module mod_mul_seq #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] op_m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic [WIDTH-1:0] add_m,
  input  logic [WIDTH-1:0] add_sum
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DBL,
    S_ADD,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_r;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_done;

  assign result = r_result;
  // done is registered off the DONE state so it rises in the same cycle
  // that the freshly written result becomes visible.
  assign done   = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_r      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= op_a;
            r_b   <= op_b;
            r_m   <= op_m;
            r_r   <= '0;
            r_cnt <= CW'(WIDTH - 1);
          end
        end
        S_DBL: r_r <= add_sum;
        S_ADD: begin
          r_r <= add_sum;
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        end
        S_DONE: r_result <= r_r;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    add_a  = '0;
    add_b  = '0;
    add_m  = '0;
    case (r_state)
      S_IDLE: if (start) w_next = S_DBL;
      S_DBL: begin
        busy   = 1'b1;
        add_a  = r_r;
        add_b  = r_r;
        add_m  = r_m;
        w_next = S_ADD;
      end
      S_ADD: begin
        busy   = 1'b1;
        add_a  = r_r;
        add_b  = r_b[r_cnt] ? r_a : '0;
        add_m  = r_m;
        w_next = (r_cnt == '0) ? S_DONE : S_DBL;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mod_mul_seq.sv
// tb_mod_mul_seq: randomized self-checking bench for mod_mul_seq.
// Provides the external modular adder and compares every result with
// (A*B) mod M computed by double-width arithmetic.
module tb_mod_mul_seq;

  localparam int W   = 256;
  localparam int LAT = 2 * W + 2;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] op_m;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic [W-1:0] add_m;
  logic [W-1:0] add_sum;
  logic [W:0]   w_sum;

  int n_checks = 0;
  int n_errors = 0;

  mod_mul_seq #(.WIDTH(W)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .op_m    (op_m),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_m   (add_m),
    .add_sum (add_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External adder: WIDTH+1-bit intermediate sum reduced mod add_m.
  always_comb begin
    w_sum = {1'b0, add_a} + {1'b0, add_b};
    if (add_m == '0) add_sum = w_sum[W-1:0];
    else             add_sum = W'(w_sum % {1'b0, add_m});
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] m);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return W'(p % {{W{1'b0}}, m});
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < W / 32; i++) v = {v[W-33:0], 32'($urandom)};
    return v;
  endfunction

  // Every-cycle protocol invariants.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    chk("done_twice", W'(prev_done & done), '0);
    chk("busy_and_done", W'(busy & done), '0);
    chk("add_idle", busy ? '0 : (add_a | add_b | add_m), '0);
    prev_done = done;
  end

  // Start one operation (called at a negedge while the DUT is idle),
  // scramble inputs after acceptance, then check latency and result.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] m, input bit want_check);
    int cyc;
    int nbusy;
    bit seen;
    logic [W-1:0] exp;
    exp   = ref_mul(a, b, m);
    op_a  = a;
    op_b  = b;
    op_m  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = rand_w();
    op_b  = rand_w();
    op_m  = rand_w();
    cyc   = 0;
    nbusy = 0;
    seen  = 1'b0;
    while (!seen && cyc < LAT + 20) begin
      @(negedge clk);
      cyc++;
      if (busy) nbusy++;
      if (done) seen = 1'b1;
    end
    chk({tag, "_latency"}, W'(cyc), W'(LAT));
    chk({tag, "_busy_cycles"}, W'(nbusy), W'(2 * W));
    if (want_check) chk(tag, result, exp);
  endtask

  initial begin
    logic [W-1:0] a, b, m, exp;
    int cyc;
    int ndone;
    bit seen;

    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    op_m  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_result", result, '0);
    chk("rst_add", add_a | add_b | add_m, '0);

    // Release reset and request on the very first edge afterwards.
    rst_n = 1'b1;
    run_op("small_3x5m7", W'(3), W'(5), W'(7), 1'b1);
    chk("small_value", result, W'(1));

    run_op("b_one", W'(64'h77BDFF316426FB2B), W'(1), W'(64'hBFD25E8CD0364141), 1'b1);
    chk("b_one_value", result, W'(64'h77BDFF316426FB2B));
    run_op("a_zero", '0, rand_w(), W'(64'hBFD25E8CD0364141), 1'b1);
    chk("a_zero_value", result, '0);

    m = '0;
    m[W-1] = 1'b1;
    m = m + W'(95);
    run_op("max_operands", m - W'(1), m - W'(1), m, 1'b1);
    chk("max_value", result, W'(1));
    run_op("b_zero", m - W'(1), '0, m, 1'b1);
    chk("b_zero_value", result, '0);

    // Result holds while idle.
    run_op("hold", W'(123456789), W'(987654321), W'(1000000007), 1'b1);
    exp = ref_mul(W'(123456789), W'(987654321), W'(1000000007));
    repeat (7) @(negedge clk);
    chk("hold_value", result, exp);

    // Random operands, issued back-to-back.
    for (int unsigned i = 0; i < 12; i++) begin
      m = rand_w();
      if (i % 3 == 1) m = m >> ($urandom_range(0, W - 2));
      if (m == '0) m = W'(1);
      a = rand_w() % m;
      b = rand_w();
      run_op("rand", a, b, m, 1'b1);
    end

    // start held high throughout; operands change mid-run.
    start = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      m = rand_w();
      if (m == '0) m = W'(1);
      a = rand_w() % m;
      b = rand_w();
      exp  = ref_mul(a, b, m);
      op_a = a;
      op_b = b;
      op_m = m;
      @(posedge clk);
      #1;
      cyc = 0;
      repeat (100) begin
        @(negedge clk);
        cyc++;
      end
      op_a = rand_w();
      op_b = rand_w();
      op_m = rand_w();
      seen = 1'b0;
      while (!seen && cyc < LAT + 20) begin
        @(negedge clk);
        cyc++;
        if (done) seen = 1'b1;
      end
      chk("held_latency", W'(cyc), W'(LAT));
      chk("held_result", result, exp);
    end
    start = 1'b0;
    @(negedge clk);

    // Reset 200 cycles into a run.
    m = rand_w() | W'(1);
    op_a  = rand_w() % m;
    op_b  = rand_w();
    op_m  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (200) @(negedge clk);
    chk("pre_reset_busy", W'(busy), W'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", W'(busy), '0);
    chk("abort_done", W'(done), '0);
    chk("abort_result", result, '0);
    chk("abort_add", add_a | add_b | add_m, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (LAT + 20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", W'(ndone), '0);
    chk("abort_result_stays", result, '0);

    m = rand_w() | W'(1);
    a = rand_w() % m;
    b = rand_w();
    run_op("after_reset", a, b, m, 1'b1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
